// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory req/ack access, pipeline stall,
// branch resolution, forwarding probe and the MEM/WB register.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        is_branch,
  input  logic        alu_zero,
  input  logic [31:0] pc_branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_type,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_t,
  input  logic [4:0]  reg_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] pc_branch_out,
  output logic [4:0]  reg_probe,
  output logic [31:0] data_probe,
  output logic        write_probe,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned BEW = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          access;
  logic [1:0]    lane_q;
  logic          byte_q;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] ld_fmt;
  logic [DW-1:0] rd_shift;
  logic [BEW-1:0] be_c;
  logic [DW-1:0] wdata_c;

  assign access = mem_read | mem_write;
  assign stall  = access & (state != DONE);

  assign branch_taken  = is_branch & alu_zero;
  assign pc_branch_out = pc_branch;

  assign reg_probe   = reg_addr;
  assign data_probe  = mem_to_reg ? ld_data : alu_out;
  assign write_probe = reg_write & (~mem_to_reg | (state == DONE));

  // Lane steering for the request and for the returning load data
  assign be_c     = mem_type ? BEW'(4'b0001 << alu_out[1:0]) : 4'b1111;
  assign wdata_c  = mem_type ? {4{data_t[7:0]}} : data_t;
  assign rd_shift = dmem_rdata >> {lane_q, 3'b000};
  assign ld_fmt   = byte_q ? {24'b0, rd_shift[7:0]} : dmem_rdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (access)   state_nxt = REQ;
      REQ:     if (dmem_ack) state_nxt = DONE;
      DONE:    if (we)       state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Bus outputs are only non-zero while the request is outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      lane_q     <= 2'b00;
      byte_q     <= 1'b0;
      ld_data    <= '0;
    end else if (state == IDLE && access) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write;
      dmem_addr  <= {alu_out[31:2], 2'b00};
      dmem_be    <= be_c;
      dmem_wdata <= wdata_c;
      lane_q     <= alu_out[1:0];
      byte_q     <= mem_type;
    end else if (state == REQ && dmem_ack) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      ld_data    <= ld_fmt;
    end
  end

  // MEM/WB register: bubble while stalled, load on we otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_reg_addr   <= '0;
      wb_alu_out    <= '0;
      wb_mem_data   <= '0;
    end else if (stall) begin
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
    end else if (we) begin
      wb_mem_to_reg <= mem_to_reg;
      wb_reg_write  <= reg_write;
      wb_reg_addr   <= reg_addr;
      wb_alu_out    <= alu_out;
      wb_mem_data   <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected bus requests
// and MEM/WB loads; a monitor compares them as the DUT presents them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, we, is_branch, alu_zero, mem_read, mem_write, mem_type;
  logic        mem_to_reg, reg_write, dmem_ack;
  logic [31:0] pc_branch, alu_out, data_t, dmem_rdata;
  logic [4:0]  reg_addr;
  logic        dmem_req, dmem_we, stall, branch_taken, write_probe;
  logic [31:0] dmem_addr, dmem_wdata, pc_branch_out, data_probe;
  logic [3:0]  dmem_be;
  logic [4:0]  reg_probe, wb_reg_addr;
  logic        wb_mem_to_reg, wb_reg_write;
  logic [31:0] wb_alu_out, wb_mem_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_t;

  typedef struct {
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  reg_addr;
    logic [31:0] alu;
    logic [31:0] mem_data;
    logic        chk_data;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];

  mem_stage dut (
    .clk(clk), .reset(reset), .we(we), .is_branch(is_branch), .alu_zero(alu_zero),
    .pc_branch(pc_branch), .mem_read(mem_read), .mem_write(mem_write),
    .mem_type(mem_type), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_out(alu_out), .data_t(data_t), .reg_addr(reg_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .branch_taken(branch_taken), .pc_branch_out(pc_branch_out),
    .reg_probe(reg_probe), .data_probe(data_probe), .write_probe(write_probe),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_reg_addr(wb_reg_addr), .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; is_branch = 0; alu_zero = 0; pc_branch = 0;
    mem_read = 0; mem_write = 0; mem_type = 0; mem_to_reg = 0; reg_write = 0;
    alu_out = 0; data_t = 0; reg_addr = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic push_bus(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d, input logic cd);
    bus_t e;
    e.addr = a; e.we = w; e.be = b; e.wdata = d; e.chk_wdata = cd;
    bus_q.push_back(e);
  endtask

  task automatic push_wb(input logic m2r, input logic rw, input logic [4:0] ra,
                         input logic [31:0] alu, input logic [31:0] md, input logic cd);
    wb_t e;
    e.mem_to_reg = m2r; e.reg_write = rw; e.reg_addr = ra;
    e.alu = alu; e.mem_data = md; e.chk_data = cd;
    wb_q.push_back(e);
  endtask

  // Monitor: new bus requests, MEM/WB loads and stall bubbles
  logic prev_req = 1'b0;
  logic wb_pending = 1'b0;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    bus_t b;
    wb_t  w;
    if (dmem_req && !prev_req) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected_req", 32'(dmem_req), 32'd0);
      end else begin
        b = bus_q.pop_front();
        chk("bus_addr", dmem_addr, b.addr);
        chk("bus_we", 32'(dmem_we), 32'(b.we));
        chk("bus_be", 32'(dmem_be), 32'(b.be));
        if (b.chk_wdata) chk("bus_wdata", dmem_wdata, b.wdata);
      end
    end
    if (wb_pending) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected_load", 32'(wb_pending), 32'd0);
      end else begin
        w = wb_q.pop_front();
        chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(w.mem_to_reg));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(w.reg_write));
        chk("wb_reg_addr", 32'(wb_reg_addr), 32'(w.reg_addr));
        chk("wb_alu_out", wb_alu_out, w.alu);
        if (w.chk_data) chk("wb_mem_data", wb_mem_data, w.mem_data);
      end
    end
    if (prev_stall) begin
      chk("bubble_reg_write", 32'(wb_reg_write), 32'd0);
      chk("bubble_mem_to_reg", 32'(wb_mem_to_reg), 32'd0);
    end
    prev_req   = dmem_req;
    wb_pending = !stall && we && !reset;
    prev_stall = stall && !reset;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) tick();
    settle();
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_wb_alu_out", wb_alu_out, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 0;

    // ALU op: no stall, loads next edge
    tick();
    alu_out = 32'h1234; reg_write = 1; reg_addr = 5'd5; we = 1;
    settle();
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_reg_probe", 32'(reg_probe), 32'd5);
    chk("alu_data_probe", data_probe, 32'h1234);
    chk("alu_write_probe", 32'(write_probe), 32'd1);
    push_wb(1'b0, 1'b1, 5'd5, 32'h1234, 32'h0, 1'b0);
    tick();
    idle_inputs();
    settle();
    chk("alu_no_req", 32'(dmem_req), 32'd0);

    // Word load, ack in the second REQ cycle
    tick();
    alu_out = 32'h103; mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_addr = 5'd7; we = 1;
    push_bus(32'h100, 1'b0, 4'b1111, 32'h0, 1'b0);
    settle();
    chk("wl_stall_c0", 32'(stall), 32'd1);
    chk("wl_write_probe_c0", 32'(write_probe), 32'd0);
    tick(); settle();
    chk("wl_stall_c1", 32'(stall), 32'd1);
    chk("wl_req_c1", 32'(dmem_req), 32'd1);
    tick();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    settle();
    chk("wl_stall_c2", 32'(stall), 32'd1);
    tick();
    dmem_ack = 0; dmem_rdata = 0;
    settle();
    chk("wl_stall_done", 32'(stall), 32'd0);
    chk("wl_req_done", 32'(dmem_req), 32'd0);
    chk("wl_data_probe", data_probe, 32'hDEADBEEF);
    chk("wl_write_probe", 32'(write_probe), 32'd1);
    push_wb(1'b1, 1'b1, 5'd7, 32'h103, 32'hDEADBEEF, 1'b1);
    tick();
    idle_inputs();

    // Byte store to lane 2, ack in the first REQ cycle
    tick();
    alu_out = 32'h202; data_t = 32'h000000A5; mem_write = 1; mem_type = 1; we = 1;
    push_bus(32'h200, 1'b1, 4'b0100, 32'hA5A5A5A5, 1'b1);
    settle();
    chk("bs_stall_c0", 32'(stall), 32'd1);
    tick();
    dmem_ack = 1;
    settle();
    chk("bs_stall_c1", 32'(stall), 32'd1);
    chk("bs_dmem_we", 32'(dmem_we), 32'd1);
    tick();
    dmem_ack = 0;
    settle();
    chk("bs_stall_done", 32'(stall), 32'd0);
    push_wb(1'b0, 1'b0, 5'd0, 32'h202, 32'h0, 1'b0);
    tick();
    idle_inputs();

    // Byte load from lane 3, we held low in DONE for a cycle
    tick();
    alu_out = 32'h3; mem_read = 1; mem_type = 1; mem_to_reg = 1; reg_write = 1;
    reg_addr = 5'd9; we = 1;
    push_bus(32'h0, 1'b0, 4'b1000, 32'h0, 1'b0);
    settle();
    chk("bl_stall_c0", 32'(stall), 32'd1);
    tick();
    dmem_ack = 1; dmem_rdata = 32'h80FF0011;
    tick();
    dmem_ack = 0; dmem_rdata = 0; we = 0;
    settle();
    chk("bl_stall_done", 32'(stall), 32'd0);
    chk("bl_data_probe", data_probe, 32'h00000080);
    chk("bl_write_probe", 32'(write_probe), 32'd1);
    tick(); settle();
    chk("bl_hold_stall", 32'(stall), 32'd0);
    chk("bl_hold_no_req", 32'(dmem_req), 32'd0);
    chk("bl_hold_data_probe", data_probe, 32'h00000080);
    we = 1;
    push_wb(1'b1, 1'b1, 5'd9, 32'h3, 32'h00000080, 1'b1);
    tick();
    idle_inputs();

    // Reset during the second REQ cycle, then a late ack
    tick();
    alu_out = 32'h400; mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_addr = 5'd3; we = 1;
    push_bus(32'h400, 1'b0, 4'b1111, 32'h0, 1'b0);
    tick();
    tick(); settle();
    chk("rs_req_before", 32'(dmem_req), 32'd1);
    idle_inputs();
    reset = 1;
    tick(); settle();
    chk("rs_req_after", 32'(dmem_req), 32'd0);
    chk("rs_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rs_wb_mem_to_reg", 32'(wb_mem_to_reg), 32'd0);
    chk("rs_wb_reg_addr", 32'(wb_reg_addr), 32'd0);
    chk("rs_wb_alu_out", wb_alu_out, 32'd0);
    chk("rs_wb_mem_data", wb_mem_data, 32'd0);
    reset = 0;
    dmem_ack = 1; dmem_rdata = 32'h12345678;
    tick();
    dmem_ack = 0; dmem_rdata = 0; mem_to_reg = 1; reg_write = 1;
    settle();
    chk("late_ack_req", 32'(dmem_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    chk("late_ack_data_probe", data_probe, 32'd0);
    chk("late_ack_write_probe", 32'(write_probe), 32'd0);
    tick();
    idle_inputs();

    // Branch resolution is combinational
    tick();
    is_branch = 1; alu_zero = 1; pc_branch = 32'h40;
    settle();
    chk("br_taken", 32'(branch_taken), 32'd1);
    chk("br_pc", pc_branch_out, 32'h40);
    alu_zero = 0;
    settle();
    chk("br_not_taken", 32'(branch_taken), 32'd0);
    tick();
    idle_inputs();

    repeat (3) tick();
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
